// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state type and default widths for the interval timer
package timer_pkg;

    localparam int CNT_W_DEFAULT = 4;
    localparam int DIV_W_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// rtl/interval_timer_ctrl_if.sv - request/status bundle; req_periodic exists only with INTERVAL_TIMER_RELOAD_EN
interface interval_timer_ctrl_if #(
    parameter int CNT_W = timer_pkg::CNT_W_DEFAULT,
    parameter int DIV_W = timer_pkg::DIV_W_DEFAULT
);

    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_count;
    logic [DIV_W-1:0] req_div;
    logic             abort;
    logic             busy;
    logic [CNT_W-1:0] remaining;
    logic             done;
    logic             aborted;

`ifdef INTERVAL_TIMER_RELOAD_EN
    logic             req_periodic;

    modport master (
        output req_valid, req_count, req_div, req_periodic, abort,
        input  req_ready, busy, remaining, done, aborted
    );

    modport slave (
        input  req_valid, req_count, req_div, req_periodic, abort,
        output req_ready, busy, remaining, done, aborted
    );
`else
    modport master (
        output req_valid, req_count, req_div, abort,
        input  req_ready, busy, remaining, done, aborted
    );

    modport slave (
        input  req_valid, req_count, req_div, abort,
        output req_ready, busy, remaining, done, aborted
    );
`endif

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - down-counting prescaler, one tick every divisor+1 enabled clocks
module tick_prescaler #(
    parameter int DIV_W = timer_pkg::DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    assign tick = enable && (cnt_q == '0);

    // The same divisor input serves the initial load and every reload after a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load || tick) begin
            cnt_q <= divisor;
        end else if (enable) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

endmodule

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - one-shot interval timer; INTERVAL_TIMER_RELOAD_EN adds periodic reload
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    interval_timer_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
`ifdef INTERVAL_TIMER_RELOAD_EN
    logic             periodic_q, periodic_d;
`endif

    logic             accept;
    logic             tick;
    logic             presc_load;
    logic [DIV_W-1:0] presc_div;

    assign accept     = (state_q == IDLE) && bus.req_valid;
    assign presc_load = accept && (bus.req_count != '0);
    assign presc_div  = accept ? bus.req_div : div_q;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .load    (presc_load),
        .enable  (state_q == RUN),
        .divisor (presc_div),
        .tick    (tick)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        div_d       = div_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
`ifdef INTERVAL_TIMER_RELOAD_EN
        periodic_d  = periodic_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    count_d = bus.req_count;
                    div_d   = bus.req_div;
`ifdef INTERVAL_TIMER_RELOAD_EN
                    periodic_d = bus.req_periodic;
`endif
                    if (bus.req_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        remaining_d = bus.req_count;
                    end
                end
            end
            RUN: begin
                // Abort wins over a final tick landing on the same edge.
                if (bus.abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                    aborted_d   = 1'b1;
                end else if (tick) begin
                    if (remaining_q <= CNT_W'(1)) begin
                        done_d = 1'b1;
`ifdef INTERVAL_TIMER_RELOAD_EN
                        if (periodic_q) begin
                            remaining_d = count_q;
                        end else begin
                            state_d     = IDLE;
                            remaining_d = '0;
                        end
`else
                        state_d     = IDLE;
                        remaining_d = '0;
`endif
                    end else begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            div_q       <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            div_q       <= div_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

`ifdef INTERVAL_TIMER_RELOAD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            periodic_q <= 1'b0;
        end else begin
            periodic_q <= periodic_d;
        end
    end
`endif

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.remaining = remaining_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;

endmodule
